// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the load/store responder: state encoding, RV32I
// funct3 codes, access sizing, byte masks and load extension.
package data_mem_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_WR1,
    ST_RESP
  } state_e;

  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;
  localparam logic [31:0] BASE_DEFAULT = 32'h1001_0000;

  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   access_size = 3'd1;
      2'b01:   access_size = 3'd2;
      default: access_size = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) funct3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else          funct3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                                 (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] raw);
    case (f3)
      F3_B:    load_extend = {{24{raw[7]}}, raw[7:0]};
      F3_H:    load_extend = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   load_extend = {24'd0, raw[7:0]};
      F3_HU:   load_extend = {16'd0, raw[15:0]};
      default: load_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_dmem_bram.sv
// Single-port 32-bit word RAM with per-byte write enables; registered read
// data appears the cycle after a read (en with no byte enables).
module dmem_bram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we == 4'b0000) rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one outstanding request against an internal word RAM,
// word-crossing accesses split over two RAM cycles, illegal requests fault.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] BASE   = BASE_DEFAULT
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWriteData,
  output logic        oReady,
  output logic        oValid,
  output logic        oFault,
  output logic [31:0] oReadData
);

  localparam int          WORDS_W = ADDR_W - 2;
  localparam logic [31:0] RANGE   = 32'd1 << ADDR_W;

  state_e               state_q, state_d;
  logic [WORDS_W-1:0]   idx_q, idx_d;
  logic [1:0]           off_q, off_d;
  logic [2:0]           f3_q, f3_d;
  logic                 cross_q, cross_d;
  logic                 fault_q, fault_d;
  logic [3:0]           be_hi_q, be_hi_d;
  logic [31:0]          wd_hi_q, wd_hi_d;
  logic [31:0]          word0_q, word0_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 ram_en;
  logic [3:0]           ram_we;
  logic [WORDS_W-1:0]   ram_addr;
  logic [31:0]          ram_wdata;
  logic [31:0]          ram_rdata;

  logic [31:0] rel, last;
  logic [2:0]  size;
  logic        in_range, legal, crossing;
  logic [7:0]  lane_mask;
  logic [63:0] lane_data;
  logic [31:0] lo_word, hi_word, load_raw;

  // Range check covers first and last byte, so a crossing access off the top faults.
  assign rel       = iAddr - BASE;
  assign size      = access_size(iFunct3);
  assign last      = rel + {29'd0, size} - 32'd1;
  assign in_range  = (rel < RANGE) && (last < RANGE);
  assign legal     = (iMemRead ^ iMemWrite) && funct3_legal(iMemWrite, iFunct3) && in_range;
  assign crossing  = ({1'b0, iAddr[1:0]} + size) > 3'd4;
  assign lane_mask = {4'd0, size_mask(iFunct3)} << iAddr[1:0];
  assign lane_data = {32'd0, iWriteData} << {iAddr[1:0], 3'b000};

  // Second word sits above the first so one right shift merges little-endian.
  assign lo_word  = (state_q == ST_RD1) ? word0_q : ram_rdata;
  assign hi_word  = (state_q == ST_RD1) ? ram_rdata : 32'd0;
  assign load_raw = 32'({hi_word, lo_word} >> {off_q, 3'b000});

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    off_d     = off_q;
    f3_d      = f3_q;
    cross_d   = cross_q;
    fault_d   = fault_q;
    be_hi_d   = be_hi_q;
    wd_hi_d   = wd_hi_q;
    word0_d   = word0_q;
    rdata_d   = rdata_q;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = idx_q;
    ram_wdata = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (iMemRead || iMemWrite) begin
          idx_d   = rel[ADDR_W-1:2];
          off_d   = iAddr[1:0];
          f3_d    = iFunct3;
          cross_d = crossing;
          be_hi_d = lane_mask[7:4];
          wd_hi_d = lane_data[63:32];
          fault_d = !legal;
          if (!legal) begin
            state_d = ST_RESP;
          end else begin
            ram_en   = 1'b1;
            ram_addr = rel[ADDR_W-1:2];
            if (iMemWrite) begin
              ram_we    = lane_mask[3:0];
              ram_wdata = lane_data[31:0];
              state_d   = crossing ? ST_WR1 : ST_RESP;
            end else begin
              state_d = ST_RD0;
            end
          end
        end
      end
      ST_RD0: begin
        if (cross_q) begin
          ram_en   = 1'b1;
          ram_addr = idx_q + WORDS_W'(1);
          word0_d  = ram_rdata;
          state_d  = ST_RD1;
        end else begin
          rdata_d = load_extend(f3_q, load_raw);
          state_d = ST_RESP;
        end
      end
      ST_RD1: begin
        rdata_d = load_extend(f3_q, load_raw);
        state_d = ST_RESP;
      end
      ST_WR1: begin
        ram_en    = 1'b1;
        ram_addr  = idx_q + WORDS_W'(1);
        ram_we    = be_hi_q;
        ram_wdata = wd_hi_q;
        state_d   = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      off_q   <= 2'd0;
      f3_q    <= 3'd0;
      cross_q <= 1'b0;
      fault_q <= 1'b0;
      be_hi_q <= 4'd0;
      wd_hi_q <= 32'd0;
      word0_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      cross_q <= cross_d;
      fault_q <= fault_d;
      be_hi_q <= be_hi_d;
      wd_hi_q <= wd_hi_d;
      word0_q <= word0_d;
      rdata_q <= rdata_d;
    end
  end

  dmem_bram #(.AW(WORDS_W)) u_bram (
    .clk   (iClk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign oReady    = (state_q == ST_IDLE);
  assign oValid    = (state_q == ST_RESP) && !fault_q;
  assign oFault    = (state_q == ST_RESP) && fault_q;
  assign oReadData = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: hand-computed loads, stores, crossings,
// faults, mid-operation reset and back-to-back held requests.
module tb_data_mem_responder;

  localparam logic [31:0] B = 32'h1001_0000;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iMemRead, iMemWrite;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr, iWriteData;
  logic        oReady, oValid, oFault;
  logic [31:0] oReadData;

  int vectors = 0;
  int errs    = 0;

  data_mem_responder #(.ADDR_W(12), .BASE(B)) dut (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iMemRead   (iMemRead),
    .iMemWrite  (iMemWrite),
    .iFunct3    (iFunct3),
    .iAddr      (iAddr),
    .iWriteData (iWriteData),
    .oReady     (oReady),
    .oValid     (oValid),
    .oFault     (oFault),
    .oReadData  (oReadData)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns cycles from accept to response.
  task automatic op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat,
                    input logic exp_flt, input logic chk_data, input logic [31:0] exp_data);
    int   lat;
    logic flt;
    logic [31:0] rdat;
    lat = 0; flt = 1'b0; rdat = 32'd0;
    chk({tag, ".ready"}, {31'd0, oReady}, 32'd1);
    iMemRead = rd; iMemWrite = wr; iFunct3 = f3; iAddr = addr; iWriteData = wdata;
    @(posedge iClk); #1;
    iMemRead = 1'b0; iMemWrite = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge iClk);
      if (oValid || oFault) begin
        lat = i; flt = oFault; rdat = oReadData;
        break;
      end
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".fault"}, {31'd0, flt}, {31'd0, exp_flt});
    if (chk_data) chk({tag, ".data"}, rdat, exp_data);
    @(negedge iClk);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp;
  } req_t;

  req_t seq [8];

  initial begin
    iRst_n = 1'b0; iMemRead = 1'b0; iMemWrite = 1'b0;
    iFunct3 = 3'd0; iAddr = 32'd0; iWriteData = 32'd0;
    #2;
    chk("rst.ready", {31'd0, oReady}, 32'd1);
    chk("rst.valid", {31'd0, oValid}, 32'd0);
    chk("rst.fault", {31'd0, oFault}, 32'd0);
    chk("rst.rdata", oReadData, 32'd0);
    @(negedge iClk); @(negedge iClk);
    iRst_n = 1'b1;
    @(negedge iClk);

    op("sw0",  0, 1, 3'b010, B + 0, 32'hDEADBEEF, 1, 0, 0, 32'd0);
    op("lw0",  1, 0, 3'b010, B + 0, 32'd0,        2, 0, 1, 32'hDEADBEEF);
    op("lb3",  1, 0, 3'b000, B + 3, 32'd0,        2, 0, 1, 32'hFFFFFFDE);
    op("lbu3", 1, 0, 3'b100, B + 3, 32'd0,        2, 0, 1, 32'h000000DE);

    // Reset asserted while a load sits in RD0.
    iMemRead = 1'b1; iMemWrite = 1'b0; iFunct3 = 3'b010; iAddr = B; iWriteData = 32'd0;
    @(posedge iClk); #1;
    iMemRead = 1'b0;
    iRst_n = 1'b0;
    #1;
    chk("midrst.ready", {31'd0, oReady}, 32'd1);
    chk("midrst.valid", {31'd0, oValid}, 32'd0);
    chk("midrst.rdata", oReadData, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge iClk);
      chk("midrst.hold", {30'd0, oValid, oFault}, 32'd0);
    end
    iRst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      chk("midrst.after", {30'd0, oValid, oFault}, 32'd0);
    end

    op("sw4",  0, 1, 3'b010, B + 4, 32'hA5A5A5A5, 1, 0, 0, 32'd0);
    op("sh6",  0, 1, 3'b001, B + 6, 32'hFFFF8001, 1, 0, 0, 32'd0);
    op("lh6",  1, 0, 3'b001, B + 6, 32'd0,        2, 0, 1, 32'hFFFF8001);
    op("lhu6", 1, 0, 3'b101, B + 6, 32'd0,        2, 0, 1, 32'h00008001);
    op("lw4a", 1, 0, 3'b010, B + 4, 32'd0,        2, 0, 1, 32'h8001A5A5);

    op("swx5", 0, 1, 3'b010, B + 5, 32'h11223344, 2, 0, 0, 32'd0);
    op("lwx5", 1, 0, 3'b010, B + 5, 32'd0,        3, 0, 1, 32'h11223344);
    op("lbu8", 1, 0, 3'b100, B + 8, 32'd0,        2, 0, 1, 32'h00000011);
    op("lw4b", 1, 0, 3'b010, B + 4, 32'd0,        2, 0, 1, 32'h223344A5);
    op("lhx7", 1, 0, 3'b001, B + 7, 32'd0,        3, 0, 1, 32'h00001122);

    op("f.rw",    1, 1, 3'b010, B + 0,     32'h0,        1, 1, 1, 32'h00001122);
    op("f.f3",    1, 0, 3'b011, B + 0,     32'h0,        1, 1, 0, 32'd0);
    op("f.sbu",   0, 1, 3'b100, B + 0,     32'h0,        1, 1, 0, 32'd0);
    op("f.top",   1, 0, 3'b010, B + 12'hFFE, 32'h0,      1, 1, 0, 32'd0);
    op("f.low",   1, 0, 3'b010, B - 4,     32'h0,        1, 1, 0, 32'd0);
    op("lw0b",    1, 0, 3'b010, B + 0,     32'd0,        2, 0, 1, 32'hDEADBEEF);
    op("swtop",   0, 1, 3'b010, B + 12'hFFC, 32'h0BADF00D, 1, 0, 0, 32'd0);
    op("f.swx",   0, 1, 3'b010, B + 12'hFFE, 32'hFFFFFFFF, 1, 1, 0, 32'd0);
    op("lwtop",   1, 0, 3'b010, B + 12'hFFC, 32'd0,      2, 0, 1, 32'h0BADF00D);
    op("lhtop",   1, 0, 3'b001, B + 12'hFFE, 32'd0,      2, 0, 1, 32'h00000BAD);

    seq[0] = '{1'b1, 3'b010, B + 32'h100, 32'hCAFEBABE, 1, 32'd0};
    seq[1] = '{1'b1, 3'b000, B + 32'h102, 32'h00000077, 1, 32'd0};
    seq[2] = '{1'b1, 3'b001, B + 32'h107, 32'h00001234, 2, 32'd0};
    seq[3] = '{1'b1, 3'b010, B + 32'h10A, 32'h89ABCDEF, 2, 32'd0};
    seq[4] = '{1'b0, 3'b010, B + 32'h100, 32'd0, 2, 32'hCA77BABE};
    seq[5] = '{1'b0, 3'b001, B + 32'h107, 32'd0, 3, 32'h00001234};
    seq[6] = '{1'b0, 3'b010, B + 32'h10A, 32'd0, 3, 32'h89ABCDEF};
    seq[7] = '{1'b0, 3'b000, B + 32'h10B, 32'd0, 2, 32'hFFFFFFCD};

    // Next request is presented immediately and held through the busy cycles.
    iMemRead = !seq[0].wr; iMemWrite = seq[0].wr; iFunct3 = seq[0].f3;
    iAddr = seq[0].addr; iWriteData = seq[0].wdata;
    for (int k = 0; k < 8; k++) begin
      int lat;
      lat = 0;
      chk("b2b.ready", {31'd0, oReady}, 32'd1);
      @(posedge iClk); #1;
      if (k < 7) begin
        iMemRead = !seq[k+1].wr; iMemWrite = seq[k+1].wr; iFunct3 = seq[k+1].f3;
        iAddr = seq[k+1].addr; iWriteData = seq[k+1].wdata;
      end else begin
        iMemRead = 1'b0; iMemWrite = 1'b0;
      end
      @(negedge iClk);
      chk("b2b.busy", {31'd0, oReady}, 32'd0);
      for (int i = 1; i <= 8; i++) begin
        if (oValid || oFault) begin
          lat = i;
          break;
        end
        @(negedge iClk);
      end
      chk("b2b.lat", lat, seq[k].lat);
      chk("b2b.fault", {31'd0, oFault}, 32'd0);
      if (!seq[k].wr) chk("b2b.data", oReadData, seq[k].exp);
      @(negedge iClk);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge iClk);
      chk("b2b.quiet", {30'd0, oValid, oFault}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
